// File: rtl/fir_mac_engine.sv
// Multi-channel FIR multiply-accumulate engine with one shared coefficient stream.
// Each channel's result is rounded or truncated, then saturated, once per convolution.
module fir_mac_engine #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int N_TAPS     = 1021,
  parameter int ADDR_W     = 10,
  parameter int ACC_W      = 40,
  parameter int FRAC_SHIFT = 15,
  parameter int RND        = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_CH*DATA_W-1:0]   smpl_in,
  output logic                     smpl_req,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]        coef_dout,
  output logic                     busy,
  output logic                     out_vld,
  output logic [N_CH*DATA_W-1:0]   smpl_out
);

  localparam int PW = DATA_W + COEF_W;
  localparam int RS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] RND_K =
    (RND != 0 && FRAC_SHIFT > 0) ? (ONE << RS) : '0;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;
  logic [ADDR_W-1:0] tap_cnt, tap_nx;
  logic clr_acc;
  logic mac_vld;

  logic signed [ACC_W-1:0]  acc    [N_CH];
  logic signed [PW-1:0]     prod   [N_CH];
  logic signed [ACC_W-1:0]  rnd_v  [N_CH];
  logic signed [ACC_W-1:0]  sh_v   [N_CH];
  logic signed [DATA_W-1:0] s_v    [N_CH];
  logic [N_CH*DATA_W-1:0]   sat_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tap_cnt <= '0;
    end else begin
      state   <= state_nx;
      tap_cnt <= tap_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    tap_nx    = tap_cnt;
    smpl_req  = 1'b0;
    coef_addr = '0;
    clr_acc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          tap_nx   = '0;
          clr_acc  = 1'b1;
        end
      end
      RUN: begin
        smpl_req  = 1'b1;
        coef_addr = tap_cnt;
        if (tap_cnt == LAST) begin
          tap_nx   = '0;
          state_nx = DRAIN;
        end else begin
          tap_nx = tap_cnt + 1'b1;
        end
      end
      DRAIN: state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Sample and ROM data both arrive one cycle after the request.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      s_v[c]  = smpl_in[c*DATA_W +: DATA_W];
      prod[c] = s_v[c] * $signed(coef_dout);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_vld <= 1'b0;
      for (int c = 0; c < N_CH; c++) acc[c] <= '0;
    end else begin
      mac_vld <= smpl_req;
      for (int c = 0; c < N_CH; c++) begin
        if (clr_acc)
          acc[c] <= '0;
        else if (mac_vld)
          acc[c] <= acc[c] + {{(ACC_W-PW){prod[c][PW-1]}}, prod[c]};
      end
    end
  end

  always_comb begin
    sat_res = '0;
    for (int c = 0; c < N_CH; c++) begin
      rnd_v[c] = acc[c] + RND_K;
      sh_v[c]  = rnd_v[c] >>> FRAC_SHIFT;
      if (sh_v[c] > SAT_MAX)
        sat_res[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
      else if (sh_v[c] < SAT_MIN)
        sat_res[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
      else
        sat_res[c*DATA_W +: DATA_W] = sh_v[c][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      smpl_out <= '0;
    end else begin
      out_vld <= (state == DONE);
      if (state == DONE) smpl_out <= sat_res;
    end
  end

endmodule
